// File: rtl/execute_stage_mc.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch/jump resolution and an
// iterative shift-add multiplier that stalls E until the product is written to M.
module execute_stage_mc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic            flush_e,
  input  logic [3:0]      alu_ctrl_e,
  input  logic            alu_src_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic            jalr_e,
  input  logic [2:0]      br_funct3_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic [1:0]      result_src_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [RA_W-1:0] rd_e,
  input  logic [1:0]      forward_a_e,
  input  logic [1:0]      forward_b_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            busy_e,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [RA_W-1:0] rd_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] pc_plus4_m
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = $clog2(XLEN) + 1;
  localparam logic [3:0]  OpMul = 4'b1011;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   acc_q, mplier_q, mcand_q;
  logic              h_reg_write_q, h_mem_write_q;
  logic [1:0]        h_result_src_q;
  logic [RA_W-1:0]   h_rd_q;
  logic [XLEN-1:0]   h_pc_plus4_q, h_wdata_q;

  logic [XLEN-1:0]   src_a, fwd_b, src_b, alu_y, jalr_sum;
  logic [SHW-1:0]    shamt;
  logic              cond, start;

  always_comb begin
    unique case (forward_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    unique case (forward_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_e : fwd_b;
  assign shamt = src_b[SHW-1:0];

  // MUL (1011) never reaches M through this path; the FSM supplies its result.
  always_comb begin
    alu_y = '0;
    case (alu_ctrl_e)
      4'b0000: alu_y = src_a + src_b;
      4'b0001: alu_y = src_a - src_b;
      4'b0010: alu_y = src_a & src_b;
      4'b0011: alu_y = src_a | src_b;
      4'b0100: alu_y = src_a ^ src_b;
      4'b0101: alu_y = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b0110: alu_y = {{(XLEN-1){1'b0}}, src_a < src_b};
      4'b0111: alu_y = src_a << shamt;
      4'b1000: alu_y = src_a >> shamt;
      4'b1001: alu_y = $signed(src_a) >>> shamt;
      4'b1010: alu_y = src_b;
      default: alu_y = '0;
    endcase
  end

  always_comb begin
    cond = 1'b0;
    case (br_funct3_e)
      3'b000:  cond = (src_a == fwd_b);
      3'b001:  cond = (src_a != fwd_b);
      3'b100:  cond = ($signed(src_a) < $signed(fwd_b));
      3'b101:  cond = ($signed(src_a) >= $signed(fwd_b));
      3'b110:  cond = (src_a < fwd_b);
      3'b111:  cond = (src_a >= fwd_b);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum    = src_a + imm_e;
  assign pc_target_e = jalr_e ? {jalr_sum[XLEN-1:1], 1'b0} : pc_e + imm_e;

  assign start  = (state_q == StIdle) && valid_e && !flush_e && (alu_ctrl_e == OpMul);
  assign busy_e = start || (state_q == StMul);

  assign pc_src_e = valid_e && !flush_e && !busy_e && (jump_e || jalr_e || (branch_e && cond));

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StMul;
      StMul: begin
        if (flush_e)                  state_d = StIdle;
        else if (cnt_q == CW'(1))     state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operands and the instruction's M control are captured at start so later
  // forwarding changes cannot disturb the product.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      acc_q          <= '0;
      mplier_q       <= '0;
      mcand_q        <= '0;
      h_reg_write_q  <= 1'b0;
      h_mem_write_q  <= 1'b0;
      h_result_src_q <= '0;
      h_rd_q         <= '0;
      h_pc_plus4_q   <= '0;
      h_wdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mplier_q       <= src_a;
        mcand_q        <= src_b;
        acc_q          <= '0;
        cnt_q          <= CW'(XLEN);
        h_reg_write_q  <= reg_write_e;
        h_mem_write_q  <= mem_write_e;
        h_result_src_q <= result_src_e;
        h_rd_q         <= rd_e;
        h_pc_plus4_q   <= pc_plus4_e;
        h_wdata_q      <= fwd_b;
      end else if (state_q == StMul) begin
        if (mplier_q[0]) acc_q <= acc_q + mcand_q;
        mplier_q <= mplier_q >> 1;
        mcand_q  <= mcand_q << 1;
        cnt_q    <= cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= '0;
      rd_m         <= '0;
      alu_result_m <= '0;
      write_data_m <= '0;
      pc_plus4_m   <= '0;
    end else if (flush_e || busy_e || (!valid_e && state_q != StDone)) begin
      valid_m     <= 1'b0;
      reg_write_m <= 1'b0;
      mem_write_m <= 1'b0;
    end else if (state_q == StDone) begin
      valid_m      <= 1'b1;
      reg_write_m  <= h_reg_write_q;
      mem_write_m  <= h_mem_write_q;
      result_src_m <= h_result_src_q;
      rd_m         <= h_rd_q;
      alu_result_m <= acc_q;
      write_data_m <= h_wdata_q;
      pc_plus4_m   <= h_pc_plus4_q;
    end else begin
      valid_m      <= 1'b1;
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      result_src_m <= result_src_e;
      rd_m         <= rd_e;
      alu_result_m <= alu_y;
      write_data_m <= fwd_b;
      pc_plus4_m   <= pc_plus4_e;
    end
  end

endmodule

// File: doc/execute_stage_mc.md
EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width (power of two, >=8).
REQ-002 Parameter RA_W, default 5, register address width.
REQ-003 The clock SHALL be a single clock, port clk, input, 1, rising-edge.
REQ-004 The reset SHALL be port rst, input, 1: synchronous, active-high.
REQ-005 Inputs SHALL be:
- valid_e, 1: instruction valid in E.
- flush_e, 1: hazard-unit flush of E.
- alu_ctrl_e, 4: ALU opcode.
- alu_src_e, 1: B operand select, 1 = imm_e.
- branch_e, 1 / jump_e, 1 / jalr_e, 1: control-flow type.
- br_funct3_e, 3: branch condition.
- reg_write_e, 1 / mem_write_e, 1 / result_src_e, 2: control carried to M.
- rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e, result_w: XLEN each.
- rd_e, RA_W.
- forward_a_e, forward_b_e: 2 each.
REQ-006 Outputs SHALL be:
- pc_src_e, 1.
- pc_target_e, XLEN.
- busy_e, 1: stall request to the hazard unit.
- valid_m, reg_write_m, mem_write_m: 1 each.
- result_src_m, 2.
- rd_m, RA_W.
- alu_result_m, write_data_m, pc_plus4_m: XLEN each.

Function
REQ-007 Forward mux SHALL select 00 = rdN_e, 01 = result_w, 10 = alu_result_m (own M register); 11 SHALL be treated as 00.
REQ-008 SrcA SHALL be the forwarded A; SrcB SHALL be imm_e when alu_src_e = 1, else the forwarded B; write_data_m SHALL capture the forwarded B.
REQ-009 ALU ops SHALL be, all results mod 2^XLEN:
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
- 0101 SLT (signed), 0110 SLTU.
- 0111 SLL, 1000 SRL, 1001 SRA, shift amount = SrcB[log2(XLEN)-1:0].
- 1010 pass SrcB.
- 1011 MUL (low XLEN bits of product).
- Any other code SHALL yield 0.
REQ-010 Branch conditions on the forwarded A/B SHALL be: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; 010/011 SHALL be never taken.
REQ-011 pc_target_e SHALL be pc_e+imm_e; when jalr_e = 1 it SHALL be (SrcA+imm_e) with bit0 cleared; it is combinational.
REQ-012 pc_src_e SHALL equal valid_e & ~flush_e & ~busy_e & (jump_e | jalr_e | (branch_e & cond)); it is combinational.
REQ-013 The FSM states SHALL be IDLE, MUL, DONE; reset state IDLE.
REQ-014 IDLE->MUL SHALL occur when valid_e & ~flush_e & alu_ctrl_e = 1011: latch SrcA/SrcB, clear accumulator, counter = XLEN.
REQ-015 In MUL, one shift-add step SHALL be performed per cycle and the counter SHALL be decremented; the state SHALL go to DONE after the step at which the counter reaches 1 (XLEN cycles in MUL).
REQ-016 DONE->IDLE SHALL occur unconditionally; in DONE the M register SHALL capture the product and the held E control.
REQ-017 busy_e SHALL be 1 in the IDLE detect cycle of REQ-014 and throughout MUL, and 0 in DONE and otherwise: 33 cycles high for XLEN = 32.
REQ-018 MUL latency SHALL be alu_result_m valid XLEN+2 edges after the MUL first presents in E.
REQ-019 While busy_e = 1, the M register SHALL load a bubble.
REQ-020 The bubble SHALL set valid_m, reg_write_m and mem_write_m to 0; the other M fields are don't-care.
REQ-021 E inputs are held by the upstream stall; operands latched per REQ-014 SHALL make the result independent of later changes to forward/result_w.
REQ-022 flush_e in any state SHALL return the FSM to IDLE next edge, discard the product, and load a bubble into M.
REQ-023 valid_e = 0 or flush_e = 1 for a single-cycle op SHALL load a bubble into M; otherwise M SHALL capture the ALU result and control each edge.

Reset
REQ-024 On rst at a rising edge, all M outputs SHALL be set to 0, the FSM to IDLE, the counter and accumulator to 0, and busy_e to 0; rst SHALL take priority over all other inputs.
REQ-025 rst asserted mid-MUL SHALL abandon the operation; no partial product SHALL reach M.

Verification
REQ-026 ADD with rd1_e = 10, forward_b_e = 01, result_w = 20 SHALL give alu_result_m = 30 next edge, with reg_write_m and valid_m = 1.
REQ-027 BLTU with A = 0xFFFFFFFF, B = 1 SHALL give pc_src_e = 0; BLT with the same operands SHALL give pc_src_e = 1; pc_e = 100 with imm_e = 8 SHALL give pc_target_e = 108.
REQ-028 SRA with A = 0x80000000, imm_e = 4, alu_src_e = 1 SHALL give 0xF8000000; SRL SHALL give 0x08000000.
REQ-029 MUL 7*6 SHALL hold busy_e high 33 cycles, give valid_m = 0 during them, and set alu_result_m = 42 at edge 34; MUL 0xFFFFFFFF*2 SHALL give 0xFFFFFFFE.
REQ-030 flush_e at MUL cycle 10 SHALL clear busy_e next cycle, return the FSM to IDLE, and never set valid_m = 1 for that MUL.
REQ-031 rst at MUL cycle 20 SHALL set all M outputs to 0 next edge, with no result appearing afterwards.
